// File: rtl/rv32_multicycle_core.sv
`default_nettype none
// =====================================================================
// Module   : rv32_multicycle_core
// Desc     : Multi-cycle RV32I subset core (OP-IMM, LW, SW) sequenced
//            FETCH/DECODE/EXEC/MEM/WB with request/valid memory ports
//            and a sticky trap on illegal or misaligned instructions.
// Revision : 1.0 - initial release
// =====================================================================
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          NUM_REGS    = 32,
    parameter int          DATA_ADDR_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    output logic        retire_o,
    output logic        illegal_o,
    input  logic [4:0]  dbg_reg_sel_i,
    output logic [31:0] dbg_reg_data_o
);

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  LOAD      = 7'b0000011;
    localparam logic [6:0]  STORE     = 7'b0100011;
    localparam int          IDX_W     = (NUM_REGS == 16) ? 4 : 5;
    localparam logic [5:0]  NREG6     = 6'(NUM_REGS);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - DATA_ADDR_W);

    generate
        if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_num_regs
            $error("rv32_multicycle_core: NUM_REGS must be 16 or 32");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        run_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, res_q;
    logic [31:0] regs_q [NUM_REGS];

    // Instruction fields
    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_sum, w_alu;
    logic        w_legal, w_rd_ok, w_rs1_ok, w_rs2_ok, w_dbg_ok;

    assign w_opcode = ir_q[6:0];
    assign w_rd     = ir_q[11:7];
    assign w_f3     = ir_q[14:12];
    assign w_rs1    = ir_q[19:15];
    assign w_rs2    = ir_q[24:20];
    assign w_f7     = ir_q[31:25];
    assign w_imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign w_imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign w_rd_ok  = {1'b0, w_rd}  < NREG6;
    assign w_rs1_ok = {1'b0, w_rs1} < NREG6;
    assign w_rs2_ok = {1'b0, w_rs2} < NREG6;
    assign w_sum    = a_q + imm_q;
    assign w_shamt  = imm_q[4:0];

    // Legality of the instruction held in IR
    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                w_legal = w_rd_ok && w_rs1_ok;
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000)
                    w_legal = 1'b0;
                if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                    w_legal = 1'b0;
            end
            LOAD:    w_legal = (w_f3 == 3'b010) && w_rd_ok && w_rs1_ok;
            STORE:   w_legal = (w_f3 == 3'b010) && w_rs1_ok && w_rs2_ok;
            default: w_legal = 1'b0;
        endcase
    end

    // OP-IMM arithmetic on the operands latched in DECODE
    always_comb begin
        w_alu = '0;
        case (w_f3)
            3'b000:  w_alu = a_q + imm_q;
            3'b010:  w_alu = {31'd0, $signed(a_q) < $signed(imm_q)};
            3'b011:  w_alu = {31'd0, a_q < imm_q};
            3'b100:  w_alu = a_q ^ imm_q;
            3'b110:  w_alu = a_q | imm_q;
            3'b111:  w_alu = a_q & imm_q;
            3'b001:  w_alu = a_q << w_shamt;
            default: w_alu = w_f7[5] ? 32'($signed(a_q) >>> w_shamt) : (a_q >> w_shamt);
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (run_q && instr_valid_i) state_d = S_DECODE;
            S_DECODE: state_d = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_opcode == OP_IMM)        state_d = S_WB;
                else if (w_sum[1:0] != 2'b00)  state_d = S_TRAP;
                else                           state_d = S_MEM;
            end
            S_MEM:    if (mem_valid_i) state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // Datapath: IR, operands, result/address, PC and register file
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            res_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            // run_q keeps the fetch request low during the cycle reset releases
            run_q <= 1'b1;
            case (state_q)
                S_FETCH: if (run_q && instr_valid_i) ir_q <= instr_data_i;
                S_DECODE: begin
                    a_q   <= regs_q[w_rs1[IDX_W-1:0]];
                    b_q   <= regs_q[w_rs2[IDX_W-1:0]];
                    imm_q <= (w_opcode == STORE) ? w_imm_s : w_imm_i;
                end
                S_EXEC: res_q <= (w_opcode == OP_IMM) ? w_alu : w_sum;
                S_MEM: if (mem_valid_i && w_opcode == LOAD) res_q <= mem_data_i;
                S_WB: begin
                    if (w_opcode != STORE && w_rd != 5'd0)
                        regs_q[w_rd[IDX_W-1:0]] <= res_q;
                    pc_q <= pc_q + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign instr_req_o    = run_q && (state_q == S_FETCH);
    assign instr_addr_o   = pc_q;
    assign mem_req_o      = (state_q == S_MEM);
    assign mem_we_o       = (state_q == S_MEM) && (w_opcode == STORE);
    assign mem_addr_o     = (state_q == S_MEM) ? (res_q & ADDR_MASK) : 32'd0;
    assign mem_data_o     = (state_q == S_MEM) ? b_q : 32'd0;
    assign retire_o       = (state_q == S_WB);
    assign illegal_o      = (state_q == S_TRAP);
    assign w_dbg_ok       = (dbg_reg_sel_i != 5'd0) && ({1'b0, dbg_reg_sel_i} < NREG6);
    assign dbg_reg_data_o = w_dbg_ok ? regs_q[dbg_reg_sel_i[IDX_W-1:0]] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_rv32_multicycle_core.sv
`default_nettype none
// =====================================================================
// Module   : tb_rv32_multicycle_core
// Desc     : Directed + randomized bench for rv32_multicycle_core with
//            an architectural reference model and memory responders.
// Revision : 1.0 - initial release
// =====================================================================
module tb_rv32_multicycle_core;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
    localparam logic [6:0]  C_OP_IMM   = 7'b0010011;
    localparam logic [6:0]  C_LOAD     = 7'b0000011;
    localparam logic [6:0]  C_STORE    = 7'b0100011;

    logic        clk, rst_i;
    logic        instr_req_o, instr_valid_i, mem_req_o, mem_we_o, mem_valid_i;
    logic        retire_o, illegal_o;
    logic [31:0] instr_addr_o, instr_data_i, mem_addr_o, mem_data_o, mem_data_i;
    logic [31:0] dbg_reg_data_o;
    logic [4:0]  dbg_reg_sel_i;

    // RV32E instance signals
    logic        e_rst, e_instr_req, e_instr_valid, e_mem_req, e_mem_we;
    logic        e_retire, e_illegal;
    logic [31:0] e_instr_addr, e_instr_data, e_mem_addr, e_mem_data, e_dbg_data;
    logic [4:0]  e_dbg_sel;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] dmem [logic [31:0]];

    rv32_multicycle_core #(.RESET_PC(C_RESET_PC), .NUM_REGS(32), .DATA_ADDR_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_valid_i(instr_valid_i), .instr_data_i(instr_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .retire_o(retire_o), .illegal_o(illegal_o),
        .dbg_reg_sel_i(dbg_reg_sel_i), .dbg_reg_data_o(dbg_reg_data_o)
    );

    rv32_multicycle_core #(.RESET_PC(32'h0), .NUM_REGS(16), .DATA_ADDR_W(32)) u_dut_e (
        .clk_i(clk), .rst_i(e_rst),
        .instr_req_o(e_instr_req), .instr_addr_o(e_instr_addr),
        .instr_valid_i(e_instr_valid), .instr_data_i(e_instr_data),
        .mem_req_o(e_mem_req), .mem_we_o(e_mem_we), .mem_addr_o(e_mem_addr),
        .mem_data_o(e_mem_data), .mem_valid_i(1'b0), .mem_data_i(32'd0),
        .retire_o(e_retire), .illegal_o(e_illegal),
        .dbg_reg_sel_i(e_dbg_sel), .dbg_reg_data_o(e_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dmem_rd(input logic [31:0] addr);
        if (dmem.exists(addr)) return dmem[addr];
        return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], C_STORE};
    endfunction

    // Architectural result of an OP-IMM instruction
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] imm);
        case (f3)
            3'd0: return a + imm;
            3'd2: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            3'd3: return (a < imm) ? 32'd1 : 32'd0;
            3'd4: return a ^ imm;
            3'd6: return a | imm;
            3'd7: return a & imm;
            3'd1: return a << imm[4:0];
            default: return (f7 == 7'h20) ? 32'($signed(a) >>> imm[4:0]) : (a >> imm[4:0]);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = C_RESET_PC;
    endtask

    // Asserts reset mid-phase, checks outputs settle without a clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_ctrl", 32'({instr_req_o, mem_req_o, mem_we_o, retire_o, illegal_o}), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        #1 chk("req_low_at_release", 32'(instr_req_o), 32'd0);
        @(negedge clk);
        chk("req_after_release", 32'(instr_req_o), 32'd1);
        chk("pc_after_release", instr_addr_o, C_RESET_PC);
    endtask

    // Runs one instruction through the DUT and compares against the model
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, imm, result, exp_addr, exp_sdata;
        logic        legal, exp_trap, exp_mem, exp_we, served;
        int          exp_cnt, cnt, n;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
        a = m_regs[rs1];
        imm = (op == C_STORE) ? {{20{ins[31]}}, ins[31:25], ins[11:7]} : {{20{ins[31]}}, ins[31:20]};
        legal = (op == C_OP_IMM) ? !((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
              : (op == C_LOAD || op == C_STORE) ? (f3 == 3'd2) : 1'b0;
        exp_trap = 1'b0; exp_mem = 1'b0; exp_we = (op == C_STORE);
        exp_addr = a + imm; exp_sdata = m_regs[rs2]; result = 32'd0;
        if (!legal) begin
            exp_trap = 1'b1; exp_cnt = 3;
        end else if (op == C_OP_IMM) begin
            result = ref_alu(f3, f7, a, imm); exp_cnt = 4;
        end else if (exp_addr % 4 != 0) begin
            exp_trap = 1'b1; exp_cnt = 4;
        end else begin
            exp_mem = 1'b1; exp_cnt = 5 + mw;
            result = dmem_rd(exp_addr);
        end

        n = 0;
        while (!instr_req_o && n < 20) begin @(negedge clk); n++; end
        chk("fetch_req", 32'(instr_req_o), 32'd1);
        chk("fetch_addr", instr_addr_o, m_pc);
        repeat (fw) @(negedge clk);
        instr_valid_i = 1'b1; instr_data_i = ins;
        @(negedge clk);
        instr_valid_i = 1'b0; instr_data_i = $urandom;

        cnt = 2; served = 1'b0;
        while (!retire_o && !illegal_o && cnt < 64) begin
            if (mem_req_o && !served) begin
                chk("mem_req_expected", 32'(exp_mem), 32'd1);
                for (int w = 0; w <= mw; w++) begin
                    chk("mem_addr", mem_addr_o, exp_addr);
                    chk("mem_we", 32'(mem_we_o), 32'(exp_we));
                    if (exp_we) chk("mem_data", mem_data_o, exp_sdata);
                    chk("req_exclusive", 32'(instr_req_o), 32'd0);
                    if (w < mw) begin
                        instr_valid_i = 1'($urandom_range(0, 1));
                        @(negedge clk); cnt++;
                        chk("mem_req_held", 32'(mem_req_o), 32'd1);
                    end
                end
                instr_valid_i = 1'b0;
                mem_valid_i = 1'b1;
                mem_data_i = exp_we ? $urandom : dmem_rd(exp_addr);
                @(negedge clk); cnt++;
                mem_valid_i = 1'b0; mem_data_i = $urandom;
                served = 1'b1;
                if (exp_we) dmem[exp_addr] = exp_sdata;
            end else begin
                @(negedge clk); cnt++;
            end
        end

        if (exp_trap) begin
            chk("trap_flag", 32'(illegal_o), 32'd1);
            chk("trap_cycle", 32'(cnt), 32'(exp_cnt));
            repeat (4) begin
                @(negedge clk);
                chk("trap_quiet", 32'({instr_req_o, mem_req_o, retire_o, illegal_o}), 32'b0001);
            end
            do_reset();
        end else begin
            chk("retire", 32'(retire_o), 32'd1);
            chk("retire_cycle", 32'(cnt), 32'(exp_cnt));
            @(negedge clk);
            chk("retire_pulse", 32'(retire_o), 32'd0);
            if (op != C_STORE && rd != 5'd0) m_regs[rd] = result;
            m_pc = m_pc + 32'd4;
            dbg_reg_sel_i = rd;
            #1 chk("rd_value", dbg_reg_data_o, m_regs[rd]);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        int          k;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        k = $urandom_range(0, 39);
        rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7)); imm = 12'($urandom); f3 = 3'($urandom);
        if (k == 0) return {25'($urandom), 7'b0110011};
        if (k == 1) return enc_i(C_OP_IMM, 3'd1, rd, rs1, {7'($urandom_range(1, 127)), 5'($urandom)});
        if (k == 2) return enc_i(C_LOAD, 3'd0, rd, 5'd0, 12'd4);
        if (k < 24) begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return enc_i(C_OP_IMM, f3, rd, rs1, imm);
        end
        if ($urandom_range(0, 3) != 0) begin
            rs1 = 5'd0;
            imm = 12'($urandom_range(0, 15) * 4);
        end else begin
            imm = 12'($urandom_range(0, 31));
        end
        if (k < 32) return enc_s(rs1, rs2, imm);
        return enc_i(C_LOAD, 3'd2, rd, rs1, imm);
    endfunction

    task automatic e_send(input logic [31:0] ins);
        int n;
        n = 0;
        while (!e_instr_req && n < 20) begin @(negedge clk); n++; end
        chk("e_fetch_req", 32'(e_instr_req), 32'd1);
        e_instr_valid = 1'b1; e_instr_data = ins;
        @(negedge clk);
        e_instr_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_i = 1'b1; e_rst = 1'b1;
        instr_valid_i = 1'b0; instr_data_i = 32'd0;
        mem_valid_i = 1'b0; mem_data_i = 32'd0; dbg_reg_sel_i = 5'd0;
        e_instr_valid = 1'b0; e_instr_data = 32'd0; e_dbg_sel = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Directed program
        run_instr(32'h00500093, 0, 0);   // ADDI x1,x0,5
        run_instr(32'hFFF00113, 1, 0);   // ADDI x2,x0,-1
        run_instr(32'h00012213, 0, 0);   // SLTI x4,x2,0
        run_instr(32'h00113293, 2, 0);   // SLTIU x5,x2,1
        run_instr(32'h00102423, 0, 3);   // SW x1,8(x0)
        run_instr(32'h00802183, 0, 3);   // LW x3,8(x0)
        run_instr(32'h00700013, 0, 0);   // ADDI x0,x0,7
        dbg_reg_sel_i = 5'd3; #1 chk("lw_x3", dbg_reg_data_o, 32'd5);
        dbg_reg_sel_i = 5'd0; #1 chk("x0_zero", dbg_reg_data_o, 32'd0);
        run_instr(enc_i(C_OP_IMM, 3'd5, 5'd6, 5'd2, {7'h20, 5'd4}), 0, 0); // SRAI x6,x2,4
        run_instr(enc_i(C_OP_IMM, 3'd1, 5'd7, 5'd1, 12'd31), 0, 0);        // SLLI x7,x1,31
        run_instr(32'h0000007F, 0, 0);   // unknown opcode
        run_instr(32'h00602183, 0, 0);   // LW x3,6(x0): misaligned

        // Randomized program
        for (int i = 0; i < 150; i++)
            run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 3));

        // Reset while a store waits on memory; a late valid must be ignored
        run_instr(32'h00500093, 0, 0);
        n = 0;
        while (!instr_req_o && n < 20) begin @(negedge clk); n++; end
        instr_valid_i = 1'b1; instr_data_i = 32'h00102423;
        @(negedge clk);
        instr_valid_i = 1'b0;
        n = 0;
        while (!mem_req_o && n < 20) begin @(negedge clk); n++; end
        chk("mem_req_before_reset", 32'(mem_req_o), 32'd1);
        do_reset();
        mem_valid_i = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b0;
        chk("late_valid_ignored", 32'({instr_req_o, mem_req_o}), 32'b10);
        run_instr(32'h00300093, 0, 1);   // ADDI x1,x0,3
        for (int i = 0; i < 32; i++) begin
            dbg_reg_sel_i = 5'(i);
            #1 chk("dbg_sweep", dbg_reg_data_o, m_regs[i]);
        end

        // RV32E build: x15 usable, x20 traps
        @(negedge clk); e_rst = 1'b0;
        e_send(32'h00300793);            // ADDI x15,x0,3
        n = 2;
        while (!e_retire && n < 20) begin @(negedge clk); n++; end
        chk("e_retire_cycle", 32'(n), 32'd4);
        @(negedge clk);
        e_dbg_sel = 5'd15; #1 chk("e_x15", e_dbg_data, 32'd3);
        e_dbg_sel = 5'd20; #1 chk("e_x20_reads_zero", e_dbg_data, 32'd0);
        e_send(32'h00100A13);            // ADDI x20,x0,1
        n = 2;
        while (!e_illegal && n < 20) begin @(negedge clk); n++; end
        chk("e_trap_cycle", 32'(n), 32'd3);
        repeat (3) begin
            @(negedge clk);
            chk("e_trap_quiet", 32'({e_instr_req, e_mem_req, e_illegal}), 32'b001);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
